// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the pipelined MIPS core.
//
// It generates the fetch address and keeps a history of the PCs of in-flight
// instructions. A relative branch that resolves in stage BR_STAGE uses that
// history to compute its target. The unit also takes absolute jumps from
// stage 2 and honours a pipeline stall. A registered redirect strobe tells
// upstream stages to squash wrong-path instructions.
//
// Parameters
//   WIDTH      address width in bits
//   RESET_ADDR pc value after reset (multiple of 4)
//   INC        sequential fetch increment in bytes
//   BR_STAGE   stage in which branch resolves (2..5)
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-high reset
//   stall     in   freezes pc, history and pending redirect
//   branch    in   branch taken by the instruction in stage BR_STAGE
//   baddr     in   branch byte offset (two's complement, relative to its PC)
//   jump      in   absolute jump taken by the instruction in stage 2
//   jaddr     in   absolute jump target
//   pc        out  current fetch address (stage-1 PC)
//   redirect  out  high while a registered redirect is pending
//
// Handshake: there is no valid/ready pair. branch/jump are one-cycle
// qualifiers sampled only on an unstalled edge while no redirect is pending.
// Once a redirect is pending, redirect stays high until the next unstalled
// edge, and that edge loads pc from the captured target.
module pc_unit #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0,
  parameter int unsigned          INC        = 4,
  parameter int unsigned          BR_STAGE   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] baddr,
  input  logic             jump,
  input  logic [WIDTH-1:0] jaddr,
  output logic [WIDTH-1:0] pc,
  output logic             redirect
);

  // The redirect flag is the only control state. It is kept as a small
  // enum so that the state is visible and easy to bind checkers to.
  typedef enum logic {
    ST_SEQ   = 1'b0,  // sequential fetch
    ST_REDIR = 1'b1   // target captured, applied on next unstalled edge
  } state_t;

  // Targets are always word-aligned. Bits [1:0] are cleared on capture.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt, tgt_nx;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] br_sum;

  // ps[k] is the PC of the instruction in stage k. Stage 1 is pc itself,
  // so only stages 2..BR_STAGE need storage.
  logic [WIDTH-1:0] ps [2:BR_STAGE];

  assign br_sum   = ps[BR_STAGE] + baddr;
  assign redirect = (state == ST_REDIR);

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    pc_nx    = pc;
    if (!stall) begin
      if (state == ST_REDIR) begin
        // The target replaces the single wrong-path sequential fetch.
        pc_nx    = tgt;
        state_nx = ST_SEQ;
      end else begin
        pc_nx = pc + INC_W;
        // branch belongs to the older instruction, so it wins over jump.
        if (branch) begin
          tgt_nx   = br_sum & ALIGN_MASK;
          state_nx = ST_REDIR;
        end else if (jump) begin
          tgt_nx   = jaddr & ALIGN_MASK;
          state_nx = ST_REDIR;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SEQ;
      tgt   <= '0;
      pc    <= RESET_ADDR;
      for (int k = 2; k <= int'(BR_STAGE); k++) begin
        ps[k] <= RESET_ADDR;
      end
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
      pc    <= pc_nx;
      if (!stall) begin
        ps[2] <= pc;
        for (int k = 3; k <= int'(BR_STAGE); k++) begin
          ps[k] <= ps[k-1];
        end
      end
    end
  end

endmodule
